chinx_intc: RTL and testbench
=============================

Name: chinx_intc

Overview:
- Interrupt controller between the event sources (system tick, peripherals) and the CPU core's single interrupt input.
- Detects per-source events, latches them as pending and applies a mask.
- Picks the highest-priority unmasked pending source and runs a request/acknowledge/end-of-interrupt handshake with the CPU.
- One interrupt in service at a time; no nesting.

Parameters:
- NSRC, 8, number of interrupt sources; index 0 is highest priority.
- VEC_W, 3, vector width; must satisfy 2^VEC_W >= NSRC.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- src  in  NSRC  toggle-style event lines (tick inverts its line once per period); each transition of a line is one event
- cfg_we  in  1  configuration write strobe
- cfg_addr  in  2  0 = mask (1 = enabled), 1 = pending write-1-clear, 2 = software set-pending, 3 = overflow write-1-clear
- cfg_wdata  in  NSRC  configuration write data
- mask_q  out  NSRC  current mask register
- pending_q  out  NSRC  current pending register
- ovf_q  out  NSRC  sticky per-source overflow flags
- irq  out  1  interrupt request to CPU, registered
- irq_vec  out  VEC_W  index of the requested source; valid while irq = 1
- irq_ack  in  1  CPU accepts the current request; 1-cycle pulse
- eoi  in  1  CPU end-of-interrupt; 1-cycle pulse
- in_service  out  1  high while an interrupt is being serviced

Behaviour:
- Reset values:
  - sync stages, edge-detect register, mask_q, pending_q, ovf_q all 0.
  - irq 0, irq_vec 0, in_service 0, state IDLE.
  - A 2-bit warm-up counter is loaded with 2.
- Input path:
  - src passes through a 2-flop synchronizer, then a previous-value register.
  - event[i] = sync[i] XOR prev[i].
  - event is forced to 0 while the warm-up counter is nonzero, so a source line already high at reset release does not produce a spurious event.
- Latency:
  - A src transition at cycle N sets pending at the end of cycle N+3.
  - irq asserts at N+4 when the source is unmasked and the FSM is IDLE.
- Pending update, per bit, in priority order (earliest wins, later ones lose):
  1. event or software set
  2. ack clear
  3. W1C clear
- Consequences of that order:
  - An event arriving in the same cycle as an ack or a W1C on the same bit leaves pending = 1.
  - An event on a bit already pending sets ovf[i]. ovf is cleared only via cfg_addr 3; if a W1C and a new overflow coincide, the set wins.
- Masking: the mask gates only request selection. Masked sources still latch pending and overflow.
- FSM state IDLE:
  - If (pending & mask) is nonzero: go to REQ, irq <= 1, irq_vec <= lowest set index.
- FSM state REQ:
  - irq_vec is frozen. A newly pending higher-priority source does not replace it.
  - On irq_ack: go to SERV, irq <= 0, in_service <= 1, clear pending[irq_vec].
  - If the requested bit is masked or W1C-cleared before an ack arrives: withdraw to IDLE with irq <= 0. Re-arbitration happens from IDLE on the next cycle.
  - If ack and withdrawal coincide, the ack wins.
- FSM state SERV:
  - On eoi: go to IDLE, in_service <= 0.
  - A new request can be raised at the earliest one cycle after returning to IDLE.
- Ignored inputs:
  - irq_ack outside REQ.
  - eoi outside SERV.
- Config writes take effect at the end of the write cycle; the FSM sees the new mask the following cycle.
- Reset mid-handshake: everything returns to reset values, and the CPU treats the dropped irq as a withdrawal.

Test Plan:
- Reset, hold src = 8'h01, release reset, mask = 8'hFF → no pending and irq stays 0 for 20 cycles (warm-up suppression).
- mask = 8'h01, toggle src[0] at cycle N → pending_q = 8'h01 at N+3, irq = 1 with irq_vec = 0 at N+4; ack → pending_q = 0, in_service = 1; eoi → in_service = 0, state IDLE.
- mask = 8'hFF, toggle src[5] and src[2] in the same cycle → irq_vec = 2 first; after ack and eoi, irq_vec = 5.
- Request pending for src[3] in REQ; write mask = 8'h00 before ack → irq drops the next cycle and pending_q[3] stays 1; restore mask → irq reasserts with irq_vec = 3.
- Toggle src[1] twice, 4 cycles apart, with no ack → ovf_q[1] = 1; W1C via cfg_addr 3 with data 8'h02 → ovf_q = 0.
- Software set via cfg_addr 2 with data 8'h80 in the same cycle as an ack of source 7 → pending_q[7] remains 1, and irq reasserts for vector 7 after eoi.

Source files
------------

// File: rtl/chinx_intc.sv
// Interrupt controller: toggle-event detection, pending/mask/overflow registers,
// fixed-priority selection and an irq/ack/eoi handshake with a single CPU.
module chinx_intc #(
   parameter int NSRC  = 8,
   parameter int VEC_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NSRC-1:0]  src,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_addr,
   input  logic [NSRC-1:0]  cfg_wdata,
   output logic [NSRC-1:0]  mask_q,
   output logic [NSRC-1:0]  pending_q,
   output logic [NSRC-1:0]  ovf_q,
   output logic             irq,
   output logic [VEC_W-1:0] irq_vec,
   input  logic             irq_ack,
   input  logic             eoi,
   output logic             in_service
);

   typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

   state_t            state_q, state_d;
   logic [NSRC-1:0]   sync1_q, sync2_q, prev_q, prev_d;
   logic [NSRC-1:0]   mask_d, pending_d, ovf_d;
   logic [1:0]        warm_q, warm_d;
   logic [VEC_W-1:0]  irq_vec_q, irq_vec_d;
   logic [NSRC-1:0]   evt, sw_set, w1c_pend, w1c_ovf, ack_clr, req;
   logic [VEC_W-1:0]  sel_vec;
   logic              do_ack, req_live;

   // During warm-up prev follows the value sync2 is about to take, so a line
   // already high at reset release is absorbed instead of seen as a transition.
   always_comb begin
      warm_d = (warm_q != 2'd0) ? warm_q - 2'd1 : warm_q;
      prev_d = (warm_q != 2'd0) ? sync1_q : sync2_q;
      evt    = (warm_q != 2'd0) ? '0 : (sync2_q ^ prev_q);
   end

   always_comb begin
      sw_set   = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata : '0;
      w1c_pend = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : '0;
      w1c_ovf  = (cfg_we && cfg_addr == 2'd3) ? cfg_wdata : '0;
      mask_d   = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata : mask_q;
      do_ack   = (state_q == REQ) && irq_ack;
      ack_clr  = do_ack ? (NSRC'(1) << irq_vec_q) : '0;
      // set beats ack clear beats W1C
      pending_d = ((pending_q & ~w1c_pend & ~ack_clr) | evt | sw_set);
      ovf_d     = (ovf_q & ~w1c_ovf) | (evt & pending_q);
   end

   always_comb begin
      req     = pending_q & mask_q;
      sel_vec = '0;
      for (int i = NSRC - 1; i >= 0; i--)
         if (req[i]) sel_vec = VEC_W'(i);
      req_live = pending_q[irq_vec_q] & mask_q[irq_vec_q];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         prev_q    <= '0;
         warm_q    <= 2'd2;
         mask_q    <= '0;
         pending_q <= '0;
         ovf_q     <= '0;
         state_q   <= IDLE;
         irq_vec_q <= '0;
      end else begin
         sync1_q   <= src;
         sync2_q   <= sync1_q;
         prev_q    <= prev_d;
         warm_q    <= warm_d;
         mask_q    <= mask_d;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
         state_q   <= state_d;
         irq_vec_q <= irq_vec_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req != '0) state_d = REQ;
         REQ:     if (irq_ack) state_d = SERV;
                  else if (!req_live) state_d = IDLE;
         SERV:    if (eoi) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // irq and in_service are decoded straight from the state flop, so both are registered.
   always_comb begin
      irq_vec_d  = irq_vec_q;
      if (state_q == IDLE && req != '0) irq_vec_d = sel_vec;
      irq        = (state_q == REQ);
      in_service = (state_q == SERV);
      irq_vec    = irq_vec_q;
   end

endmodule

// File: tb/tb_chinx_intc.sv
// Directed bench for chinx_intc: one task per scenario, inline checks.
module tb_chinx_intc;
   logic       clk = 0, rst = 1;
   logic [7:0] src = 0, cfg_wdata = 0;
   logic       cfg_we = 0, irq_ack = 0, eoi = 0;
   logic [1:0] cfg_addr = 0;
   logic [7:0] mask_q, pending_q, ovf_q;
   logic       irq, in_service;
   logic [2:0] irq_vec;
   int tests = 0, fails = 0;

   chinx_intc #(.NSRC(8), .VEC_W(3)) dut (
      .clk(clk), .rst(rst), .src(src), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .mask_q(mask_q), .pending_q(pending_q), .ovf_q(ovf_q),
      .irq(irq), .irq_vec(irq_vec), .irq_ack(irq_ack), .eoi(eoi), .in_service(in_service));

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic cfg(input logic [1:0] a, input logic [7:0] d);
      cfg_we = 1; cfg_addr = a; cfg_wdata = d;
      tick();
      cfg_we = 0;
   endtask

   task automatic ack();
      irq_ack = 1; tick(); irq_ack = 0;
   endtask

   task automatic do_eoi();
      eoi = 1; tick(); eoi = 0;
   endtask

   task automatic test_reset();
      int bad;
      rst = 1; src = 8'h01;
      tick(3);
      tests++;
      if ({mask_q, pending_q, ovf_q, irq, irq_vec, in_service} !== 28'h0) begin
         fails++; $display("FAIL reset_state: got %h/%h/%h irq=%b vec=%0d is=%b, want all 0",
                           mask_q, pending_q, ovf_q, irq, irq_vec, in_service);
      end
      rst = 0;
      cfg(2'd0, 8'hFF);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (pending_q !== 8'h00 || irq !== 1'b0) bad++;
         tick();
      end
      tests++;
      if (bad != 0) begin
         fails++; $display("FAIL warmup: %0d cycles with pending/irq set, want 0", bad);
      end
      ack(); do_eoi();
      tests++;
      if (irq !== 0 || in_service !== 0) begin
         fails++; $display("FAIL ignored_ack_eoi: irq=%b is=%b, want 0 0", irq, in_service);
      end
   endtask

   task automatic test_basic();
      cfg(2'd0, 8'h01);
      src[0] = ~src[0];
      tick(2);
      tests++;
      if (pending_q !== 8'h00) begin
         fails++; $display("FAIL early_pending: got %h want 00", pending_q);
      end
      tick();
      tests++;
      if (pending_q !== 8'h01 || irq !== 0) begin
         fails++; $display("FAIL pend_n3: pending=%h irq=%b, want 01 0", pending_q, irq);
      end
      tick();
      tests++;
      if (irq !== 1 || irq_vec !== 3'd0) begin
         fails++; $display("FAIL irq_n4: irq=%b vec=%0d, want 1 0", irq, irq_vec);
      end
      ack();
      tests++;
      if (pending_q !== 8'h00 || in_service !== 1 || irq !== 0) begin
         fails++; $display("FAIL ack: pending=%h is=%b irq=%b, want 00 1 0", pending_q, in_service, irq);
      end
      do_eoi();
      tests++;
      if (in_service !== 0 || irq !== 0) begin
         fails++; $display("FAIL eoi: is=%b irq=%b, want 0 0", in_service, irq);
      end
   endtask

   task automatic test_priority();
      cfg(2'd0, 8'hFF);
      src[5] = ~src[5]; src[2] = ~src[2];
      tick(4);
      tests++;
      if (irq !== 1 || irq_vec !== 3'd2 || pending_q !== 8'h24) begin
         fails++; $display("FAIL prio_first: irq=%b vec=%0d pend=%h, want 1 2 24", irq, irq_vec, pending_q);
      end
      ack(); do_eoi();
      tick();
      tests++;
      if (irq !== 1 || irq_vec !== 3'd5) begin
         fails++; $display("FAIL prio_second: irq=%b vec=%0d, want 1 5", irq, irq_vec);
      end
      ack(); do_eoi();
   endtask

   task automatic test_withdraw();
      src[3] = ~src[3];
      tick(4);
      tests++;
      if (irq !== 1 || irq_vec !== 3'd3) begin
         fails++; $display("FAIL wd_req: irq=%b vec=%0d, want 1 3", irq, irq_vec);
      end
      cfg(2'd0, 8'h00);
      tick();
      tests++;
      if (irq !== 0 || pending_q[3] !== 1) begin
         fails++; $display("FAIL wd_drop: irq=%b pend3=%b, want 0 1", irq, pending_q[3]);
      end
      cfg(2'd0, 8'hFF);
      tick();
      tests++;
      if (irq !== 1 || irq_vec !== 3'd3) begin
         fails++; $display("FAIL wd_rearm: irq=%b vec=%0d, want 1 3", irq, irq_vec);
      end
      ack(); do_eoi();
   endtask

   task automatic test_overflow();
      cfg(2'd0, 8'h00);
      src[1] = ~src[1];
      tick(4);
      src[1] = ~src[1];
      tick(4);
      tests++;
      if (ovf_q !== 8'h02 || pending_q !== 8'h02 || irq !== 0) begin
         fails++; $display("FAIL ovf_set: ovf=%h pend=%h irq=%b, want 02 02 0", ovf_q, pending_q, irq);
      end
      cfg(2'd3, 8'h02);
      tests++;
      if (ovf_q !== 8'h00) begin
         fails++; $display("FAIL ovf_w1c: ovf=%h, want 00", ovf_q);
      end
      cfg(2'd1, 8'hFF);
      tests++;
      if (pending_q !== 8'h00) begin
         fails++; $display("FAIL pend_w1c: pend=%h, want 00", pending_q);
      end
   endtask

   task automatic test_swset_ack();
      cfg(2'd0, 8'hFF);
      src[7] = ~src[7];
      tick(4);
      tests++;
      if (irq !== 1 || irq_vec !== 3'd7) begin
         fails++; $display("FAIL sw_req: irq=%b vec=%0d, want 1 7", irq, irq_vec);
      end
      irq_ack = 1; cfg_we = 1; cfg_addr = 2'd2; cfg_wdata = 8'h80;
      tick();
      irq_ack = 0; cfg_we = 0;
      tests++;
      if (pending_q !== 8'h80 || in_service !== 1) begin
         fails++; $display("FAIL sw_vs_ack: pend=%h is=%b, want 80 1", pending_q, in_service);
      end
      do_eoi();
      tick();
      tests++;
      if (irq !== 1 || irq_vec !== 3'd7) begin
         fails++; $display("FAIL sw_rearm: irq=%b vec=%0d, want 1 7", irq, irq_vec);
      end
   endtask

   task automatic test_reset_mid();
      rst = 1;
      tick();
      rst = 0;
      tests++;
      if (irq !== 0 || pending_q !== 8'h00 || mask_q !== 8'h00 || in_service !== 0) begin
         fails++; $display("FAIL reset_mid: irq=%b pend=%h mask=%h is=%b, want 0 00 00 0",
                           irq, pending_q, mask_q, in_service);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_withdraw();
      test_overflow();
      test_swset_ack();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
